// File: rtl/usb_crc_pkg.sv
// Shared types and polynomial constants for the USB serial CRC engines.
// CRC5 covers token packets, CRC16 covers data packets.
package usb_crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        APPEND,
        DONE
    } crc_state_e;

    typedef enum logic {
        CRC_GEN,
        CRC_CHK
    } crc_mode_e;

    // Polynomials omit the implicit x^WIDTH term.
    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_RES   = 5'h0C;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_RES  = 16'h800D;

endpackage

// File: rtl/crc_serial_engine_if.sv
// Handshake bundle between the serial CRC engine and the packet FSMs.
interface crc_serial_engine_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             mode;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_last;
    logic             crc_ack;
    logic             done_ack;
    logic             crc_bit;
    logic             crc_valid;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [WIDTH-1:0] crc_value;

    modport master (
        output start, mode, bit_valid, bit_in, bit_last, crc_ack, done_ack,
        input  crc_bit, crc_valid, busy, done, crc_ok, crc_value
    );

    modport slave (
        input  start, mode, bit_valid, bit_in, bit_last, crc_ack, done_ack,
        output crc_bit, crc_valid, busy, done, crc_ok, crc_value
    );

endinterface

// File: rtl/crc_lfsr_step.sv
// One-bit LFSR next-state function; fb_en=0 gives a plain zero-fill left shift.
module crc_lfsr_step #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h8005
) (
    input  logic [WIDTH-1:0] lfsr,
    input  logic             d,
    input  logic             fb_en,
    output logic [WIDTH-1:0] lfsr_nxt
);

    logic fb;

    assign fb       = fb_en & (lfsr[WIDTH-1] ^ d);
    assign lfsr_nxt = {lfsr[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: GEN appends the complemented remainder
// MSB first under crc_valid/crc_ack, CHK compares the final register to the residual.
module crc_serial_engine
    import usb_crc_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] POLY     = CRC16_POLY,
    parameter logic [WIDTH-1:0] INIT     = '1,
    parameter logic [WIDTH-1:0] RESIDUAL = CRC16_RES
) (
    input logic                clk,
    input logic                rst_n,
    crc_serial_engine_if.slave bus
);

    localparam int unsigned           CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WIDTH - 1);

    crc_state_e       state;
    crc_mode_e        mode_q;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic             crc_valid_q;
    logic             crc_ok_q;

    // Feedback only while absorbing payload; APPEND just drains the register.
    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .lfsr     (lfsr),
        .d        (bus.bit_in),
        .fb_en    (state == SHIFT),
        .lfsr_nxt (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= CRC_GEN;
            lfsr        <= INIT;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
        end else if (bus.start) begin
            // start aborts whatever is in flight.
            state       <= SHIFT;
            mode_q      <= crc_mode_e'(bus.mode);
            lfsr        <= INIT;
            cnt         <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    if (bus.bit_valid) begin
                        lfsr <= lfsr_nxt;
                        if (bus.bit_last) begin
                            if (mode_q == CRC_CHK) begin
                                state    <= DONE;
                                done_q   <= 1'b1;
                                crc_ok_q <= (lfsr_nxt == RESIDUAL);
                            end else begin
                                state       <= APPEND;
                                cnt         <= '0;
                                crc_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                APPEND: begin
                    if (bus.crc_ack) begin
                        lfsr <= lfsr_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state       <= DONE;
                            crc_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            crc_ok_q    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (bus.done_ack) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                        crc_ok_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.crc_bit   = crc_valid_q & ~lfsr[WIDTH-1];
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_value = ~lfsr;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: a CRC16 and a CRC5 instance share one stimulus set.
module tb_crc_serial_engine;
    import usb_crc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crc_serial_engine_if #(.WIDTH(16)) if16 ();
    crc_serial_engine_if #(.WIDTH(5))  if5  ();

    crc_serial_engine #(
        .WIDTH(16), .POLY(CRC16_POLY), .INIT(16'hFFFF), .RESIDUAL(CRC16_RES)
    ) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    crc_serial_engine #(
        .WIDTH(5), .POLY(CRC5_POLY), .INIT(5'h1F), .RESIDUAL(CRC5_RES)
    ) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

    // sel picks which engine sees the stimulus and drives the observed outputs.
    logic sel, start, mode, bit_valid, bit_in, bit_last, crc_ack, done_ack;

    assign if16.start     = start & ~sel;
    assign if16.mode      = mode;
    assign if16.bit_valid = bit_valid & ~sel;
    assign if16.bit_in    = bit_in;
    assign if16.bit_last  = bit_last;
    assign if16.crc_ack   = crc_ack & ~sel;
    assign if16.done_ack  = done_ack & ~sel;
    assign if5.start      = start & sel;
    assign if5.mode       = mode;
    assign if5.bit_valid  = bit_valid & sel;
    assign if5.bit_in     = bit_in;
    assign if5.bit_last   = bit_last;
    assign if5.crc_ack    = crc_ack & sel;
    assign if5.done_ack   = done_ack & sel;

    logic        o_crc_bit, o_crc_valid, o_busy, o_done, o_crc_ok;
    logic [15:0] o_crc_value;
    assign o_crc_bit   = sel ? if5.crc_bit   : if16.crc_bit;
    assign o_crc_valid = sel ? if5.crc_valid : if16.crc_valid;
    assign o_busy      = sel ? if5.busy      : if16.busy;
    assign o_done      = sel ? if5.done      : if16.done;
    assign o_crc_ok    = sel ? if5.crc_ok    : if16.crc_ok;
    assign o_crc_value = sel ? {11'b0, if5.crc_value} : if16.crc_value;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = v[i];
            bit_last  = (i == n - 1);
            tick();
        end
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic collect(input int nbits, input int stall_at,
                           output logic [31:0] crc, output logic [31:0] val0);
        logic        hold_bit;
        logic [15:0] hold_val;
        crc  = '0;
        val0 = '0;
        for (int k = 0; k < nbits; k++) begin
            int t = 0;
            while (!o_crc_valid && t < 20) begin
                tick();
                t++;
            end
            if (!o_crc_valid) begin
                check_val("crc_valid_timeout", o_crc_valid, 1);
                break;
            end
            if (k == 0) val0 = o_crc_value;
            if (k == stall_at) begin
                crc_ack  = 1'b0;
                hold_bit = o_crc_bit;
                hold_val = o_crc_value;
                repeat (7) begin
                    tick();
                    check_val("stall_valid", o_crc_valid, 1);
                    check_val("stall_bit", o_crc_bit, hold_bit);
                    check_val("stall_value", o_crc_value, hold_val);
                end
            end
            crc     = {crc[30:0], o_crc_bit};
            crc_ack = 1'b1;
            tick();
        end
        crc_ack = 1'b0;
    endtask

    task automatic ack_done();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check_val("idle_after_ack", o_busy, 0);
    endtask

    task automatic run_gen(input logic s, input logic [63:0] v, input int n, input int w,
                           input int stall_at, output logic [31:0] crc);
        logic [31:0] val0;
        sel = s;
        start_op(CRC_GEN);
        send_bits(v, n);
        check_val("gen_valid_rise", o_crc_valid, 1);
        collect(w, stall_at, crc, val0);
        check_val("gen_bits_vs_value", crc, val0);
        check_val("gen_done", o_done, 1);
        check_val("gen_crc_ok_zero", o_crc_ok, 0);
        ack_done();
    endtask

    task automatic run_chk(input logic s, input logic [63:0] v, input int n, output logic ok);
        sel = s;
        start_op(CRC_CHK);
        send_bits(v, n);
        check_val("chk_done_rise", o_done, 1);
        ok = o_crc_ok;
    endtask

    function automatic logic [63:0] append_crc(input logic [63:0] p, input int n,
                                               input logic [31:0] crc, input int w);
        logic [63:0] v = p;
        for (int k = 0; k < w; k++) v[n + k] = crc[w - 1 - k];
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] crc, crc2, crc5, val0;
        logic [63:0] v16, v5;
        logic        ok;
        logic [15:0] frozen;

        sel = 0; start = 0; mode = 0; bit_valid = 0; bit_in = 0; bit_last = 0;
        crc_ack = 0; done_ack = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy16", if16.busy, 0);
        check_val("rst_done16", if16.done, 0);
        check_val("rst_valid16", if16.crc_valid, 0);
        check_val("rst_ok16", if16.crc_ok, 0);
        check_val("rst_bit16", if16.crc_bit, 0);
        check_val("rst_value16", if16.crc_value, 16'h0000);
        check_val("rst_value5", if5.crc_value, 5'h00);
        rst_n = 1'b1;
        tick();

        // CRC16 of a single 0 bit: lfsr FFFF -> 7FFB, appended value 8004.
        run_gen(1'b0, 64'h0, 1, 16, -1, crc);
        check_val("t1_crc16", crc, 32'h8004);

        // Loopback of bytes 00 01 02 03, then single-bit corruptions.
        run_gen(1'b0, 64'h03020100, 32, 16, -1, crc2);
        v16 = append_crc(64'h03020100, 32, crc2, 16);
        run_chk(1'b0, v16, 48, ok);
        check_val("t2_loop_ok", ok, 1);
        ack_done();
        run_chk(1'b0, v16 ^ (64'h1 << 5), 48, ok);
        check_val("t2_flip_payload", ok, 0);
        ack_done();
        run_chk(1'b0, v16 ^ (64'h1 << 40), 48, ok);
        check_val("t2_flip_crc", ok, 0);
        ack_done();

        // CRC5 token 0x547 sent LSB first: remainder 00010, appended 11101.
        run_gen(1'b1, 64'h547, 11, 5, -1, crc5);
        check_val("t3_crc5", crc5, 32'h1D);
        v5 = append_crc(64'h547, 11, crc5, 5);
        run_chk(1'b1, v5, 16, ok);
        check_val("t3_loop_ok", ok, 1);
        ack_done();
        run_chk(1'b1, v5 ^ (64'h1 << 15), 16, ok);
        check_val("t3_flip_last", ok, 0);
        ack_done();

        // Consumer stall in the middle of APPEND.
        run_gen(1'b0, 64'h0, 1, 16, 3, crc);
        check_val("t4_stall_crc", crc, 32'h8004);

        // Abort with start after 8 appended bits, then a clean rerun.
        sel = 1'b0;
        start_op(CRC_GEN);
        send_bits(64'h0, 1);
        collect(8, -1, crc, val0);
        check_val("t5_partial", crc, 32'h80);
        start_op(CRC_GEN);
        check_val("t5_valid_drop", o_crc_valid, 0);
        check_val("t5_busy", o_busy, 1);
        check_val("t5_no_done", o_done, 0);
        check_val("t5_init", o_crc_value, 16'h0000);
        send_bits(64'h0, 1);
        collect(16, -1, crc, val0);
        check_val("t5_rerun_crc", crc, 32'h8004);
        check_val("t5_done", o_done, 1);
        ack_done();

        // Async reset in SHIFT; done_ack outside DONE is ignored first.
        sel = 1'b0;
        start_op(CRC_CHK);
        done_ack  = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (3) tick();
        bit_valid = 1'b0;
        done_ack  = 1'b0;
        check_val("t6_shift_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", o_busy, 0);
        check_val("t6_rst_done", o_done, 0);
        check_val("t6_rst_valid", o_crc_valid, 0);
        check_val("t6_rst_ok", o_crc_ok, 0);
        check_val("t6_rst_bit", o_crc_bit, 0);
        check_val("t6_rst_value", o_crc_value, 16'h0000);
        #3 rst_n = 1'b1;
        tick();
        tick();
        check_val("t6_no_done_pulse", o_done, 0);

        // DONE persists without done_ack; stray bit_valid/crc_ack ignored.
        run_chk(1'b0, v16, 48, ok);
        frozen = o_crc_value;
        crc_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            tick();
        end
        bit_valid = 1'b0;
        crc_ack   = 1'b0;
        check_val("t6_done_held", o_done, 1);
        check_val("t6_ok_held", o_crc_ok, 1);
        check_val("t6_value_frozen", o_crc_value, frozen);
        ack_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
